// File: rtl/core_pkg.sv
// Shared core definitions: privilege levels, trap causes, Zicsr operations,
// machine-mode CSR addresses and field positions used by the trap CSR file.
package core_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  typedef enum logic [3:0] {
    EXC_INSTR_MISALIGNED = 4'd0,
    EXC_INSTR_FAULT      = 4'd1,
    EXC_ILLEGAL_INSTR    = 4'd2,
    EXC_BREAKPOINT       = 4'd3,
    EXC_LOAD_MISALIGNED  = 4'd4,
    EXC_LOAD_FAULT       = 4'd5,
    EXC_STORE_MISALIGNED = 4'd6,
    EXC_STORE_FAULT      = 4'd7,
    EXC_ECALL_U          = 4'd8,
    EXC_ECALL_M          = 4'd11
  } exception_e;

  typedef enum logic [3:0] {
    INT_M_SOFTWARE = 4'd3,
    INT_M_TIMER    = 4'd7,
    INT_M_EXTERNAL = 4'd11
  } interrupt_e;

  typedef enum logic [1:0] {
    CSR_RW = 2'd0,
    CSR_RS = 2'd1,
    CSR_RC = 2'd2
  } csr_op_e;

  // Which implemented CSR the current address selects.
  typedef enum logic [3:0] {
    CSR_SEL_NONE,
    CSR_SEL_MSTATUS,
    CSR_SEL_MISA,
    CSR_SEL_MIE,
    CSR_SEL_MTVEC,
    CSR_SEL_MSCRATCH,
    CSR_SEL_MEPC,
    CSR_SEL_MCAUSE,
    CSR_SEL_MTVAL,
    CSR_SEL_MIP,
    CSR_SEL_RO
  } csr_sel_e;

  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MVENDORID = 12'hF11;
  localparam logic [11:0] CSR_MARCHID   = 12'hF12;
  localparam logic [11:0] CSR_MIMPID    = 12'hF13;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MSTATUS_MPP_LO   = 11;
  localparam int MSTATUS_MPP_HI   = 12;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIP_MEIP_BIT     = 11;

  localparam logic [1:0] MTVEC_MODE_DIRECT   = 2'd0;
  localparam logic [1:0] MTVEC_MODE_VECTORED = 2'd1;

  // Zicsr read-modify-write; an unknown op leaves the register unchanged.
  function automatic logic [31:0] csr_apply(csr_op_e op, logic [31:0] old_val,
                                            logic [31:0] wdata);
    case (op)
      CSR_RW:  return wdata;
      CSR_RS:  return old_val | wdata;
      CSR_RC:  return old_val & ~wdata;
      default: return old_val;
    endcase
  endfunction

endpackage

// File: rtl/core_csr_decode.sv
// Combinational CSR address decode, access legality check and read mux.
// Ports: csr_addr/csr_write/priv describe the access; *_val are the current
// architectural views of each CSR; csr_sel names the target, csr_illegal
// flags an illegal access, csr_rdata is the pre-write read value.
module core_csr_decode
  import core_pkg::*;
#(
  parameter logic [31:0] MISA_VALUE = 32'h4010_0100,
  parameter logic [31:0] HART_ID    = 32'd0
) (
  input  logic [11:0] csr_addr,
  input  logic        csr_write,
  input  priv_e       priv,
  input  logic [31:0] mstatus_val,
  input  logic [31:0] mie_val,
  input  logic [31:0] mtvec_val,
  input  logic [31:0] mscratch_val,
  input  logic [31:0] mepc_val,
  input  logic [31:0] mcause_val,
  input  logic [31:0] mtval_val,
  input  logic [31:0] mip_val,
  output csr_sel_e    csr_sel,
  output logic        csr_illegal,
  output logic [31:0] csr_rdata
);

  // NOTE: every output of a combinational block gets a default first so no
  // path through the case statement leaves it unassigned (no latch).
  always_comb begin
    csr_sel   = CSR_SEL_NONE;
    csr_rdata = '0;
    case (csr_addr)
      CSR_MSTATUS:  begin csr_sel = CSR_SEL_MSTATUS;  csr_rdata = mstatus_val;  end
      CSR_MISA:     begin csr_sel = CSR_SEL_MISA;     csr_rdata = MISA_VALUE;   end
      CSR_MIE:      begin csr_sel = CSR_SEL_MIE;      csr_rdata = mie_val;      end
      CSR_MTVEC:    begin csr_sel = CSR_SEL_MTVEC;    csr_rdata = mtvec_val;    end
      CSR_MSCRATCH: begin csr_sel = CSR_SEL_MSCRATCH; csr_rdata = mscratch_val; end
      CSR_MEPC:     begin csr_sel = CSR_SEL_MEPC;     csr_rdata = mepc_val;     end
      CSR_MCAUSE:   begin csr_sel = CSR_SEL_MCAUSE;   csr_rdata = mcause_val;   end
      CSR_MTVAL:    begin csr_sel = CSR_SEL_MTVAL;    csr_rdata = mtval_val;    end
      CSR_MIP:      begin csr_sel = CSR_SEL_MIP;      csr_rdata = mip_val;      end
      CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID: csr_sel = CSR_SEL_RO;
      CSR_MHARTID:  begin csr_sel = CSR_SEL_RO;       csr_rdata = HART_ID;      end
      default: ;
    endcase
  end

  // addr[9:8] encodes the lowest privilege allowed; addr[11:10]==3 is read-only.
  assign csr_illegal = (csr_sel == CSR_SEL_NONE)
                     | (csr_addr[9:8] > 2'(priv))
                     | (csr_write & (csr_addr[11:10] == 2'b11));

endmodule

// File: rtl/core_trap_csr.sv
// Machine-mode trap CSR file. Takes exceptions/interrupts and MRET on the
// step strobe, updates mepc/mcause/mtval/mstatus, computes trap_pc and
// mret_pc, and serves Zicsr accesses (csr_* in, csr_rdata and
// ex_csr_illegal_instr out). priv/cfg_mie/cfg_meie feed the trap handler.
module core_trap_csr
  import core_pkg::*;
#(
  parameter logic [31:0] MISA_VALUE = 32'h4010_0100,
  parameter logic [31:0] HART_ID    = 32'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        step,
  input  logic        exception_valid,
  input  exception_e  exception_cause,
  input  logic [31:0] exception_value,
  input  logic        interrupt_valid,
  input  interrupt_e  interrupt_cause,
  input  logic [31:0] pc,
  input  logic        mret,
  input  logic        csr_en,
  input  csr_op_e     csr_op,
  input  logic        csr_write,
  input  logic [11:0] csr_addr,
  input  logic [31:0] csr_wdata,
  output logic [31:0] csr_rdata,
  output logic        ex_csr_illegal_instr,
  input  logic        int_m_ext,
  output priv_e       priv,
  output logic        cfg_mie,
  output logic        cfg_meie,
  output logic        trap_taken,
  output logic [31:0] trap_pc,
  output logic [31:0] mret_pc
);

  priv_e       priv_q, priv_d;
  logic        mstat_mie_q, mstat_mie_d;
  logic        mstat_mpie_q, mstat_mpie_d;
  priv_e       mstat_mpp_q, mstat_mpp_d;
  logic        mie_meie_q, mie_meie_d;
  logic [29:0] mtvec_base_q, mtvec_base_d;
  logic        mtvec_mode_q, mtvec_mode_d;   // only DIRECT/VECTORED are storable
  logic [31:0] mscratch_q, mscratch_d;
  logic [29:0] mepc_q, mepc_d;
  logic [31:0] mcause_q, mcause_d;
  logic [31:0] mtval_q, mtval_d;

  logic [31:0] mstatus_val, mie_val, mip_val, mtvec_val, mepc_val;
  csr_sel_e    csr_sel;
  logic        csr_illegal;
  logic        mret_illegal;
  logic        do_trap, do_mret, do_csr;
  logic [3:0]  trap_cause;
  logic [31:0] csr_new;

  assign mstatus_val = {19'b0, mstat_mpp_q, 3'b0, mstat_mpie_q, 3'b0, mstat_mie_q, 3'b0};
  assign mie_val     = {20'b0, mie_meie_q, 11'b0};
  assign mip_val     = {20'b0, int_m_ext, 11'b0};
  assign mtvec_val   = {mtvec_base_q, 1'b0, mtvec_mode_q};
  assign mepc_val    = {mepc_q, 2'b00};

  core_csr_decode #(
    .MISA_VALUE (MISA_VALUE),
    .HART_ID    (HART_ID)
  ) u_decode (
    .csr_addr     (csr_addr),
    .csr_write    (csr_write),
    .priv         (priv_q),
    .mstatus_val  (mstatus_val),
    .mie_val      (mie_val),
    .mtvec_val    (mtvec_val),
    .mscratch_val (mscratch_q),
    .mepc_val     (mepc_val),
    .mcause_val   (mcause_q),
    .mtval_val    (mtval_q),
    .mip_val      (mip_val),
    .csr_sel      (csr_sel),
    .csr_illegal  (csr_illegal),
    .csr_rdata    (csr_rdata)
  );

  assign trap_taken   = interrupt_valid | exception_valid;
  assign trap_cause   = interrupt_valid ? 4'(interrupt_cause) : 4'(exception_cause);
  assign trap_pc      = (mtvec_mode_q & interrupt_valid)
                      ? {mtvec_base_q, 2'b00} + {26'b0, trap_cause, 2'b00}
                      : {mtvec_base_q, 2'b00};
  assign mret_illegal = mret & (priv_q != PRIV_M);
  assign ex_csr_illegal_instr = (csr_en & csr_illegal) | mret_illegal;

  // A trap in the same step suppresses MRET and any CSR write.
  assign do_trap = step & trap_taken;
  assign do_mret = step & mret & ~mret_illegal & ~trap_taken;
  assign do_csr  = step & csr_en & csr_write & ~csr_illegal & ~trap_taken;
  assign csr_new = csr_apply(csr_op, csr_rdata, csr_wdata);

  assign priv     = priv_q;
  assign cfg_mie  = mstat_mie_q;
  assign cfg_meie = mie_meie_q;
  assign mret_pc  = mepc_val;

  always_comb begin
    priv_d       = priv_q;
    mstat_mie_d  = mstat_mie_q;
    mstat_mpie_d = mstat_mpie_q;
    mstat_mpp_d  = mstat_mpp_q;
    mie_meie_d   = mie_meie_q;
    mtvec_base_d = mtvec_base_q;
    mtvec_mode_d = mtvec_mode_q;
    mscratch_d   = mscratch_q;
    mepc_d       = mepc_q;
    mcause_d     = mcause_q;
    mtval_d      = mtval_q;

    if (do_csr) begin
      case (csr_sel)
        CSR_SEL_MSTATUS: begin
          mstat_mie_d  = csr_new[MSTATUS_MIE_BIT];
          mstat_mpie_d = csr_new[MSTATUS_MPIE_BIT];
          // MPP only accepts U or M; S and the reserved encoding are dropped.
          if (csr_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == PRIV_U ||
              csr_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO] == PRIV_M)
            mstat_mpp_d = priv_e'(csr_new[MSTATUS_MPP_HI:MSTATUS_MPP_LO]);
        end
        CSR_SEL_MIE:      mie_meie_d = csr_new[MIE_MEIE_BIT];
        CSR_SEL_MTVEC: begin
          mtvec_base_d = csr_new[31:2];
          if (csr_new[1:0] == MTVEC_MODE_DIRECT || csr_new[1:0] == MTVEC_MODE_VECTORED)
            mtvec_mode_d = csr_new[0];
        end
        CSR_SEL_MSCRATCH: mscratch_d = csr_new;
        CSR_SEL_MEPC:     mepc_d     = csr_new[31:2];
        CSR_SEL_MCAUSE:   mcause_d   = csr_new;
        CSR_SEL_MTVAL:    mtval_d    = csr_new;
        default: ;   // misa, mip and read-only IDs ignore writes
      endcase
    end

    if (do_mret) begin
      priv_d       = mstat_mpp_q;
      mstat_mie_d  = mstat_mpie_q;
      mstat_mpie_d = 1'b1;
      mstat_mpp_d  = PRIV_U;
    end

    if (do_trap) begin
      mepc_d       = pc[31:2];
      mcause_d     = {interrupt_valid, 27'b0, trap_cause};
      mtval_d      = interrupt_valid ? 32'b0 : exception_value;
      mstat_mpie_d = mstat_mie_q;
      mstat_mie_d  = 1'b0;
      mstat_mpp_d  = priv_q;
      priv_d       = PRIV_M;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      priv_q       <= PRIV_M;
      mstat_mie_q  <= 1'b0;
      mstat_mpie_q <= 1'b0;
      mstat_mpp_q  <= PRIV_M;
      mie_meie_q   <= 1'b0;
      mtvec_base_q <= '0;
      mtvec_mode_q <= 1'b0;
      mscratch_q   <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      priv_q       <= priv_d;
      mstat_mie_q  <= mstat_mie_d;
      mstat_mpie_q <= mstat_mpie_d;
      mstat_mpp_q  <= mstat_mpp_d;
      mie_meie_q   <= mie_meie_d;
      mtvec_base_q <= mtvec_base_d;
      mtvec_mode_q <= mtvec_mode_d;
      mscratch_q   <= mscratch_d;
      mepc_q       <= mepc_d;
      mcause_q     <= mcause_d;
      mtval_q      <= mtval_d;
    end
  end

endmodule

// File: tb/tb_core_trap_csr.sv
// Self-checking bench for core_trap_csr: directed scenarios followed by
// random traffic, all compared against a CSR-word reference model.
module tb_core_trap_csr;
  import core_pkg::*;

  localparam logic [31:0] MISA = 32'h4010_0100;
  localparam logic [31:0] HART = 32'd0;

  logic        clk = 1'b0;
  logic        rst;
  logic        step;
  logic        exception_valid;
  exception_e  exception_cause;
  logic [31:0] exception_value;
  logic        interrupt_valid;
  interrupt_e  interrupt_cause;
  logic [31:0] pc;
  logic        mret;
  logic        csr_en;
  csr_op_e     csr_op;
  logic        csr_write;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        ex_csr_illegal_instr;
  logic        int_m_ext;
  priv_e       priv;
  logic        cfg_mie;
  logic        cfg_meie;
  logic        trap_taken;
  logic [31:0] trap_pc;
  logic [31:0] mret_pc;

  core_trap_csr #(.MISA_VALUE(MISA), .HART_ID(HART)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .step                 (step),
    .exception_valid      (exception_valid),
    .exception_cause      (exception_cause),
    .exception_value      (exception_value),
    .interrupt_valid      (interrupt_valid),
    .interrupt_cause      (interrupt_cause),
    .pc                   (pc),
    .mret                 (mret),
    .csr_en               (csr_en),
    .csr_op               (csr_op),
    .csr_write            (csr_write),
    .csr_addr             (csr_addr),
    .csr_wdata            (csr_wdata),
    .csr_rdata            (csr_rdata),
    .ex_csr_illegal_instr (ex_csr_illegal_instr),
    .int_m_ext            (int_m_ext),
    .priv                 (priv),
    .cfg_mie              (cfg_mie),
    .cfg_meie             (cfg_meie),
    .trap_taken           (trap_taken),
    .trap_pc              (trap_pc),
    .mret_pc              (mret_pc)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: whole CSR words keyed by address, plus current privilege.
  logic [31:0] m_csr [int];
  int          m_priv;

  task automatic m_reset();
    m_csr.delete();
    m_csr[int'(CSR_MSTATUS)]   = 32'h0000_1800;
    m_csr[int'(CSR_MISA)]      = MISA;
    m_csr[int'(CSR_MIE)]       = 32'h0;
    m_csr[int'(CSR_MTVEC)]     = 32'h0;
    m_csr[int'(CSR_MSCRATCH)]  = 32'h0;
    m_csr[int'(CSR_MEPC)]      = 32'h0;
    m_csr[int'(CSR_MCAUSE)]    = 32'h0;
    m_csr[int'(CSR_MTVAL)]     = 32'h0;
    m_csr[int'(CSR_MIP)]       = 32'h0;
    m_csr[int'(CSR_MVENDORID)] = 32'h0;
    m_csr[int'(CSR_MARCHID)]   = 32'h0;
    m_csr[int'(CSR_MIMPID)]    = 32'h0;
    m_csr[int'(CSR_MHARTID)]   = HART;
    m_priv = 3;
  endtask

  function automatic logic [31:0] m_read(logic [11:0] a);
    if (a == CSR_MIP) return int_m_ext ? 32'h0000_0800 : 32'h0;
    if (m_csr.exists(int'(a))) return m_csr[int'(a)];
    return 32'h0;
  endfunction

  // Bits software may change in each CSR.
  function automatic logic [31:0] m_mask(logic [11:0] a);
    case (a)
      CSR_MSTATUS: return 32'h0000_1888;
      CSR_MIE:     return 32'h0000_0800;
      CSR_MTVEC, CSR_MSCRATCH, CSR_MCAUSE, CSR_MTVAL: return 32'hFFFF_FFFF;
      CSR_MEPC:    return 32'hFFFF_FFFC;
      default:     return 32'h0;
    endcase
  endfunction

  function automatic bit m_illegal(logic [11:0] a, logic wr);
    return !m_csr.exists(int'(a)) || (int'(a[9:8]) > m_priv) || (wr && a[11:10] == 2'b11);
  endfunction

  logic [31:0] last_rdata;
  logic        last_ill;
  logic [31:0] last_trap_pc;

  task automatic idle();
    step = 1'b0; exception_valid = 1'b0; exception_cause = EXC_ILLEGAL_INSTR;
    exception_value = '0; interrupt_valid = 1'b0; interrupt_cause = INT_M_EXTERNAL;
    pc = '0; mret = 1'b0; csr_en = 1'b0; csr_op = CSR_RW; csr_write = 1'b0;
    csr_addr = '0; csr_wdata = '0; int_m_ext = 1'b0;
  endtask

  // Called just after a falling edge with inputs applied: checks all
  // combinational outputs, then advances the model across the rising edge.
  task automatic tick();
    logic [31:0] e_rd, e_pc, mt, ms, old_v, nv, mask;
    bit          ill_csr, e_ill, e_trap, mie_b;
    int          cause, key;
    #1;
    e_rd    = m_read(csr_addr);
    ill_csr = m_illegal(csr_addr, csr_write);
    e_ill   = (csr_en && ill_csr) || (mret && m_priv != 3);
    e_trap  = interrupt_valid || exception_valid;
    cause   = interrupt_valid ? int'(interrupt_cause) : int'(exception_cause);
    mt      = m_csr[int'(CSR_MTVEC)];
    e_pc    = {mt[31:2], 2'b00};
    if (interrupt_valid && mt[1:0] == 2'd1) e_pc = e_pc + 32'(4 * cause);
    ms = m_csr[int'(CSR_MSTATUS)];
    nv = m_csr[int'(CSR_MIE)];
    check("csr_rdata", csr_rdata, e_rd);
    check("ex_csr_illegal_instr", 32'(ex_csr_illegal_instr), 32'(e_ill));
    check("trap_taken", 32'(trap_taken), 32'(e_trap));
    if (e_trap) check("trap_pc", trap_pc, e_pc);
    check("priv", 32'(priv), 32'(m_priv));
    check("cfg_mie", 32'(cfg_mie), 32'(ms[3]));
    check("cfg_meie", 32'(cfg_meie), 32'(nv[11]));
    check("mret_pc", mret_pc, m_csr[int'(CSR_MEPC)]);
    last_rdata = csr_rdata; last_ill = ex_csr_illegal_instr; last_trap_pc = trap_pc;

    @(posedge clk);
    if (step) begin
      if (e_trap) begin
        m_csr[int'(CSR_MEPC)]   = pc & 32'hFFFF_FFFC;
        m_csr[int'(CSR_MCAUSE)] = (interrupt_valid ? 32'h8000_0000 : 32'h0) | 32'(cause);
        m_csr[int'(CSR_MTVAL)]  = interrupt_valid ? 32'h0 : exception_value;
        mie_b     = ms[3];
        ms[7]     = mie_b;
        ms[3]     = 1'b0;
        ms[12:11] = 2'(m_priv);
        m_csr[int'(CSR_MSTATUS)] = ms;
        m_priv = 3;
      end else begin
        if (csr_en && csr_write && !ill_csr) begin
          key   = int'(csr_addr);
          old_v = e_rd;
          case (csr_op)
            CSR_RW:  nv = csr_wdata;
            CSR_RS:  nv = old_v | csr_wdata;
            default: nv = old_v & ~csr_wdata;
          endcase
          if (csr_addr == CSR_MSTATUS && (nv[12:11] == 2'd1 || nv[12:11] == 2'd2))
            nv[12:11] = old_v[12:11];
          if (csr_addr == CSR_MTVEC && nv[1:0] > 2'd1) nv[1:0] = old_v[1:0];
          mask = m_mask(csr_addr);
          m_csr[key] = (m_csr[key] & ~mask) | (nv & mask);
        end
        if (mret && m_priv == 3) begin
          ms = m_csr[int'(CSR_MSTATUS)];
          m_priv    = int'(ms[12:11]);
          ms[3]     = ms[7];
          ms[7]     = 1'b1;
          ms[12:11] = 2'b00;
          m_csr[int'(CSR_MSTATUS)] = ms;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic csr(csr_op_e op, logic [11:0] a, logic [31:0] d, logic wr);
    idle();
    step = 1'b1; csr_en = 1'b1; csr_op = op; csr_addr = a; csr_wdata = d; csr_write = wr;
    tick();
  endtask

  task automatic rd(logic [11:0] a);
    csr(CSR_RS, a, 32'h0, 1'b0);
  endtask

  task automatic do_mret();
    idle(); step = 1'b1; mret = 1'b1; tick();
  endtask

  logic [11:0] addr_list [17] = '{
    CSR_MSTATUS, CSR_MISA, CSR_MIE, CSR_MTVEC, CSR_MSCRATCH, CSR_MEPC, CSR_MCAUSE,
    CSR_MTVAL, CSR_MIP, CSR_MVENDORID, CSR_MARCHID, CSR_MIMPID, CSR_MHARTID,
    12'h302, 12'h7C0, 12'h100, 12'hC00};
  exception_e exc_list [6] = '{EXC_INSTR_FAULT, EXC_ILLEGAL_INSTR, EXC_BREAKPOINT,
                               EXC_LOAD_FAULT, EXC_ECALL_U, EXC_ECALL_M};
  interrupt_e int_list [3] = '{INT_M_SOFTWARE, INT_M_TIMER, INT_M_EXTERNAL};

  initial begin
    int r;
    idle();
    rst = 1'b1;
    m_reset();
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset_priv", 32'(priv), 32'd3);
    check("reset_trap_taken", 32'(trap_taken), 32'd0);
    check("reset_mret_pc", mret_pc, 32'd0);
    rd(CSR_MSTATUS);
    check("reset_mstatus", last_rdata, 32'h0000_1800);

    // Vectored interrupt taken from U mode.
    csr(CSR_RW, CSR_MTVEC, 32'h8000_0001, 1'b1);
    csr(CSR_RW, CSR_MIE, 32'h0000_0800, 1'b1);
    csr(CSR_RW, CSR_MSTATUS, 32'h0, 1'b1);
    do_mret();
    check("priv_u_after_mret", 32'(priv), 32'd0);
    idle(); step = 1'b1; interrupt_valid = 1'b1; interrupt_cause = INT_M_EXTERNAL;
    pc = 32'h100; int_m_ext = 1'b1;
    tick();
    check("int_trap_pc", last_trap_pc, 32'h8000_002C);
    rd(CSR_MCAUSE); check("int_mcause", last_rdata, 32'h8000_000B);
    rd(CSR_MEPC);   check("int_mepc", last_rdata, 32'h100);
    rd(CSR_MTVAL);  check("int_mtval", last_rdata, 32'h0);
    check("int_priv", 32'(priv), 32'd3);
    rd(CSR_MSTATUS); check("int_mpp_u", last_rdata & 32'h1800, 32'h0);

    // Illegal-instruction exception from U mode with MIE=1.
    csr(CSR_RW, CSR_MSTATUS, 32'h0000_0080, 1'b1);
    do_mret();
    check("mie_before_exc", 32'(cfg_mie), 32'd1);
    idle(); step = 1'b1; exception_valid = 1'b1; exception_cause = EXC_ILLEGAL_INSTR;
    exception_value = 32'hDEAD_BEEF; pc = 32'h204;
    tick();
    check("exc_trap_pc", last_trap_pc, 32'h8000_0000);
    rd(CSR_MCAUSE); check("exc_mcause", last_rdata, 32'h2);
    rd(CSR_MTVAL);  check("exc_mtval", last_rdata, 32'hDEAD_BEEF);
    rd(CSR_MSTATUS); check("exc_mstatus", last_rdata, 32'h0000_0080);

    // MRET back to U, then an illegal MRET in U mode.
    check("mret_pc_204", mret_pc, 32'h204);
    do_mret();
    check("mret_priv_u", 32'(priv), 32'd0);
    check("mret_mie", 32'(cfg_mie), 32'd1);
    do_mret();
    check("mret_in_u_illegal", 32'(last_ill), 32'd1);
    check("mret_in_u_priv", 32'(priv), 32'd0);

    // Back to M through an ECALL, then CSR read-modify-write ops.
    idle(); step = 1'b1; exception_valid = 1'b1; exception_cause = EXC_ECALL_U; pc = 32'h300;
    tick();
    csr(CSR_RW, CSR_MSCRATCH, 32'h0000_F0F0, 1'b1); rd(CSR_MSCRATCH);
    check("mscratch_rw", last_rdata, 32'h0000_F0F0);
    csr(CSR_RS, CSR_MSCRATCH, 32'h0000_000F, 1'b1); rd(CSR_MSCRATCH);
    check("mscratch_rs", last_rdata, 32'h0000_F0FF);
    csr(CSR_RC, CSR_MSCRATCH, 32'h0000_00F0, 1'b1); rd(CSR_MSCRATCH);
    check("mscratch_rc", last_rdata, 32'h0000_F00F);
    csr(CSR_RS, CSR_MHARTID, 32'h0, 1'b0);
    check("mhartid_read_legal", 32'(last_ill), 32'd0);
    check("mhartid_value", last_rdata, 32'h0);
    csr(CSR_RS, CSR_MHARTID, 32'h5, 1'b1);
    check("mhartid_write_illegal", 32'(last_ill), 32'd1);

    // Trap beats a simultaneous CSR write.
    idle(); step = 1'b1; exception_valid = 1'b1; exception_cause = EXC_BREAKPOINT;
    exception_value = 32'h1234; pc = 32'h400;
    csr_en = 1'b1; csr_op = CSR_RW; csr_addr = CSR_MSCRATCH; csr_wdata = 32'hAAAA; csr_write = 1'b1;
    tick();
    rd(CSR_MSCRATCH); check("trap_blocks_write", last_rdata, 32'h0000_F00F);
    rd(CSR_MCAUSE);   check("trap_with_write_mcause", last_rdata, 32'h3);

    // MPP WARL and step-low hold.
    csr(CSR_RW, CSR_MSTATUS, 32'h0000_0800, 1'b1);
    rd(CSR_MSTATUS); check("mpp_warl", last_rdata & 32'h1800, 32'h1800);
    idle(); csr_en = 1'b1; csr_addr = CSR_MSCRATCH; csr_wdata = 32'h5555; csr_write = 1'b1;
    tick();
    rd(CSR_MSCRATCH); check("step_low_hold", last_rdata, 32'h0000_F00F);

    // Random traffic against the model.
    for (int i = 0; i < 500; i++) begin
      idle();
      r = int'($urandom_range(0, 99));
      step            = ($urandom_range(0, 9) != 0);
      pc              = $urandom;
      exception_value = $urandom;
      int_m_ext       = 1'($urandom_range(0, 1));
      exception_cause = exc_list[$urandom_range(0, 5)];
      interrupt_cause = int_list[$urandom_range(0, 2)];
      csr_op          = csr_op_e'($urandom_range(0, 2));
      csr_addr        = addr_list[$urandom_range(0, 16)];
      csr_wdata       = $urandom;
      csr_write       = 1'($urandom_range(0, 1));
      if (r < 8) begin
        interrupt_valid = 1'b1;
        exception_valid = (r < 3);
        csr_en          = 1'($urandom_range(0, 1));
      end else if (r < 16) begin
        exception_valid = 1'b1;
        csr_en          = 1'($urandom_range(0, 1));
      end else if (r < 28) begin
        mret = 1'b1;
      end else begin
        csr_en = 1'b1;
      end
      tick();
    end

    // Reset asserted mid-trap restores reset values immediately.
    idle(); step = 1'b1; interrupt_valid = 1'b1; interrupt_cause = INT_M_TIMER; pc = 32'h7770;
    #2 rst = 1'b1;
    #1;
    check("rst_async_priv", 32'(priv), 32'd3);
    check("rst_async_mret_pc", mret_pc, 32'd0);
    check("rst_async_meie", 32'(cfg_meie), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    m_reset();
    idle();
    rd(CSR_MCAUSE); check("rst_mcause", last_rdata, 32'h0);
    rd(CSR_MSTATUS); check("rst_mstatus", last_rdata, 32'h0000_1800);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
